// File: rtl/nibble_cpu_core_p.sv
// Accumulator CPU core: two-word fetch/op cycle over a narrow memory bus, A/B registers,
// carry flag, loads/stores and 8-bit-target jumps with a self-incrementing program counter.
module nibble_cpu_core_p #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 6
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [DATA_W-1:0] data_in,
    output logic [PC_W-1:0]   addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              wr,
    output logic              sync,
    output logic              carry
);

    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_AND = 4'h1;
    localparam logic [3:0] OP_OR  = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SRA = 4'h6;
    localparam logic [3:0] OP_ADD = 4'h7;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_JNE = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_LDA = 4'hC;
    localparam logic [3:0] OP_LDB = 4'hD;
    localparam logic [3:0] OP_STA = 4'hE;
    localparam logic [3:0] OP_STB = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_OP    = 2'd1,
        ST_OPND1 = 2'd2,
        ST_OPND2 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] tmp_q, tmp_d;
    logic              carry_q, carry_d;
    logic [3:0]        op_q, op_d;

    logic [3:0]        opcode;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W:0]   sum;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic              taken;
    logic              is_store;

    assign opcode = data_in[3:0];
    assign shamt  = b_q[SH_W-1:0];
    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign pc_inc = pc_q + PC_W'(1);
    // Target bits above PC_W are simply dropped.
    assign target = PC_W'({tmp_q, data_in});

    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_JC:   taken = carry_q;
            OP_JNE:  taken = (a_q != b_q);
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        carry_d = carry_q;
        op_d    = op_q;

        case (state_q)
            ST_FETCH: begin
                pc_d    = pc_inc;
                state_d = ST_OP;
            end
            ST_OP: begin
                pc_d    = pc_inc;
                op_d    = opcode;
                state_d = (opcode >= OP_JC) ? ST_OPND1 : ST_FETCH;
                // ALU results land on this edge, so ALU instructions take two cycles.
                case (opcode)
                    OP_AND: a_d = a_q & b_q;
                    OP_OR:  a_d = a_q | b_q;
                    OP_XOR: a_d = a_q ^ b_q;
                    OP_SLL: a_d = a_q << shamt;
                    OP_SRL: a_d = a_q >> shamt;
                    OP_SRA: a_d = $unsigned($signed(a_q) >>> shamt);
                    OP_ADD: {carry_d, a_d} = sum;
                    OP_SUB: begin
                        a_d     = a_q - b_q;
                        carry_d = (a_q < b_q);
                    end
                    default: a_d = a_q;
                endcase
            end
            ST_OPND1: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
                case (op_q)
                    OP_LDA: a_d = data_in;
                    OP_LDB: b_d = data_in;
                    OP_JC, OP_JNE, OP_JMP: begin
                        tmp_d   = data_in;
                        state_d = ST_OPND2;
                    end
                    default: tmp_d = tmp_q;
                endcase
            end
            ST_OPND2: begin
                pc_d    = taken ? target : pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tmp_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmp_q   <= tmp_d;
            carry_q <= carry_d;
            op_q    <= op_d;
        end
    end

    // Store data goes out on the operand slot's address; the operand word is overwritten.
    assign is_store = (state_q == ST_OPND1) && ((op_q == OP_STA) || (op_q == OP_STB));
    assign wr       = is_store;
    assign data_out = !is_store ? '0 : ((op_q == OP_STA) ? a_q : b_q);
    assign addr_out = pc_q;
    assign sync     = (state_q == ST_FETCH);
    assign carry    = carry_q;

endmodule
